alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Command front-end that sits directly upstream of the 12-bit combinational ALU and also registers what the ALU produces.
- Buffers incoming ALU commands in a small FIFO.
- Drives the ALU operand/select inputs from registers.
- Captures the ALU result and compare flags one cycle later into a valid/ready response register.
- Keeps an accumulator so a command can use the previous result as operand a, which allows chained operations without a round-trip through software.

Parameters:
- WIDTH, 12, operand/result width; must match the ALU.
- SELW, 4, opcode width; must match the ALU select.
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals (fifo_count < DEPTH).
- cmd_sel  in  SELW  ALU opcode.
- cmd_a  in  WIDTH  operand a; ignored when cmd_use_acc=1.
- cmd_b  in  WIDTH  operand b.
- cmd_use_acc  in  1  use acc in place of cmd_a.
- alu_a  out  WIDTH  registered operand to ALU a.
- alu_b  out  WIDTH  registered operand to ALU b.
- alu_sel  out  SELW  registered opcode to ALU sel.
- alu_result  in  WIDTH  ALU result.
- alu_agrtb  in  1  ALU a>b flag.
- alu_altb  in  1  ALU a<b flag.
- alu_aeqb  in  1  ALU a==b flag.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts.
- rsp_result  out  WIDTH  captured result.
- rsp_flags  out  3  {agrtb, altb, aeqb}, captured.
- acc  out  WIDTH  last captured result.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst_n low, async):
  - FIFO empty, pointers 0, state IDLE.
  - alu_a, alu_b, alu_sel, rsp_result, rsp_flags, acc, rsp_valid all 0.
  - cmd_ready=1, since it is derived from fifo_count=0.
  - Any in-flight command is discarded; rsp_valid drops immediately.
- Push: on a clock edge with cmd_valid && cmd_ready, store {sel, a, b, use_acc} at the write pointer.
  - Pointers wrap modulo DEPTH.
  - When full, cmd_ready=0 even if a pop happens that cycle; there is no same-cycle pass-through.
- FSM, 2 states:
  - IDLE: if fifo_count>0 && (!rsp_valid || rsp_ready):
    - load alu_a <= head.use_acc ? acc : head.a;
    - load alu_b <= head.b and alu_sel <= head.sel;
    - pop the head; go to EXEC.
    - Otherwise stay in IDLE and hold the alu_* registers unchanged.
  - EXEC (exactly 1 cycle, ALU settles):
    - rsp_result <= alu_result, rsp_flags <= {alu_agrtb, alu_altb, alu_aeqb}, acc <= alu_result;
    - rsp_valid <= 1; go to IDLE.
- Response handshake:
  - rsp_valid stays high, with rsp_result/rsp_flags stable, until a clock edge with rsp_ready=1.
  - On that edge rsp_valid clears, unless EXEC captures on the same edge. By construction it cannot: issue requires the slot to be free at the issue edge.
- Latency: command accepted on edge N → alu_* valid after edge N+1 (FIFO was empty, response slot free) → rsp_valid high after edge N+2.
- Throughput: 1 command per 2 cycles.
- Simultaneous push and pop in IDLE: fifo_count is unchanged.
- Accumulator:
  - acc is updated only in EXEC and is visible to the next issue, so back-to-back chained commands see the prior result.
  - acc=0 after reset.
- Arithmetic:
  - The sequencer does not modify data. Results are the ALU's WIDTH-bit value, wrapping modulo 2^WIDTH.
  - Flags are the ALU's signed compare of alu_a and alu_b.
- Storage capacity with rsp_ready held low: 1 captured response + DEPTH queued commands.

Test Plan:
- Reset:
  - Assert rst_n low mid-run → rsp_valid=0, acc=0, alu_a=alu_b=0, alu_sel=0, fifo_count=0, cmd_ready=1.
- Single op:
  - Push a=5, b=3, sel=0100 (add), rsp_ready=1 → alu_a=5 after edge N+1.
  - rsp_valid after N+2 with rsp_result=8, rsp_flags=3'b100.
- Chain:
  - Push {a=10, b=0, sel=0011} → response 10.
  - Push {use_acc=1, b=7, sel=0100} → response 17.
  - Push {use_acc=1, b=17, sel=0101} → response 0, flags 3'b001.
- Back-pressure:
  - Hold rsp_ready=0 and push 6 commands → exactly 5 accepted, then cmd_ready=0 and fifo_count=4.
  - The first response is held stable.
  - Release rsp_ready → 5 responses in push order, no loss or duplication.
- Wrap:
  - Stream 10 commands {a=i, b=1, sel=1001}, i=0..9, with random rsp_ready → results 2i+5 in order.
  - Pointers wrap twice; fifo_count never exceeds 4.
- Reset mid-EXEC:
  - Drop rst_n during the EXEC cycle → rsp_valid=0 immediately, FIFO empty.
  - After release, push a=-1, b=1, sel=0100 → result 0, flags 3'b010.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Command front-end for a WIDTH-bit combinational ALU. Incoming commands are
// queued in a DEPTH-entry FIFO. A two-state FSM issues the head command to
// registered ALU operand/select outputs, then captures the ALU result and
// compare flags one cycle later into a valid/ready response register. The
// captured result is also kept as an accumulator, so a later command can use
// it as operand a and chain operations without a round trip through software.
//
// Ports:
//   clk, rst_n               clock; asynchronous active-low reset
//   cmd_valid / cmd_ready    command handshake (cmd_ready = fifo_count < DEPTH)
//   cmd_sel, cmd_a, cmd_b    opcode and operands of the incoming command
//   cmd_use_acc              take operand a from acc instead of cmd_a
//   alu_a, alu_b, alu_sel    registered operands/opcode driven to the ALU
//   alu_result, alu_agrtb,
//   alu_altb, alu_aeqb       ALU result and signed compare flags
//   rsp_valid / rsp_ready    response handshake
//   rsp_result, rsp_flags    captured result and {agrtb, altb, aeqb}
//   acc                      last captured result
//   fifo_count               number of queued commands

module alu_op_sequencer #(
    parameter int WIDTH = 12,
    parameter int SELW  = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [SELW-1:0]          cmd_sel,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic                     cmd_use_acc,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [SELW-1:0]          alu_sel,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_agrtb,
    input  logic                     alu_altb,
    input  logic                     alu_aeqb,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_result,
    output logic [2:0]               rsp_flags,
    output logic [WIDTH-1:0]         acc,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    state_t state;

    // Command storage; contents need no reset because the pointers and count
    // define which entries are live.
    logic [SELW-1:0]  q_sel     [DEPTH];
    logic [WIDTH-1:0] q_a       [DEPTH];
    logic [WIDTH-1:0] q_b       [DEPTH];
    logic             q_use_acc [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Readiness comes only from the registered count, so a pop in the same
    // cycle never opens a slot for a simultaneous push when full.
    assign cmd_ready = (fifo_count < FULL_COUNT);
    assign push      = cmd_valid && cmd_ready;

    // Issue only when the response slot will be free at this edge, which
    // guarantees EXEC never captures on top of an unconsumed response.
    assign pop = (state == IDLE) && (fifo_count != '0) && (!rsp_valid || rsp_ready);

    always_ff @(posedge clk) begin
        if (push) begin
            q_sel[wr_ptr]     <= cmd_sel;
            q_a[wr_ptr]       <= cmd_a;
            q_b[wr_ptr]       <= cmd_b;
            q_use_acc[wr_ptr] <= cmd_use_acc;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            acc        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                    if (pop) begin
                        alu_a   <= q_use_acc[rd_ptr] ? acc : q_a[rd_ptr];
                        alu_b   <= q_b[rd_ptr];
                        alu_sel <= q_sel[rd_ptr];
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= {alu_agrtb, alu_altb, alu_aeqb};
                    acc        <= alu_result;
                    rsp_valid  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//
// Drives alu_op_sequencer together with a stand-in combinational ALU and
// compares every consumed response against an in-order reference model of the
// command stream (accumulator chaining included).

module tb_alu_op_sequencer;

    localparam int WIDTH = 12;
    localparam int SELW  = 4;
    localparam int DEPTH = 4;

    localparam logic [SELW-1:0] OP_PASS = 4'b0011;
    localparam logic [SELW-1:0] OP_ADD  = 4'b0100;
    localparam logic [SELW-1:0] OP_SUB  = 4'b0101;
    localparam logic [SELW-1:0] OP_XOR  = 4'b0110;
    localparam logic [SELW-1:0] OP_MAC  = 4'b1001;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [SELW-1:0]       cmd_sel;
    logic [WIDTH-1:0]      cmd_a;
    logic [WIDTH-1:0]      cmd_b;
    logic                  cmd_use_acc;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [SELW-1:0]       alu_sel;
    logic [WIDTH-1:0]      alu_result;
    logic                  alu_agrtb;
    logic                  alu_altb;
    logic                  alu_aeqb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_result;
    logic [2:0]            rsp_flags;
    logic [WIDTH-1:0]      acc;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(WIDTH), .SELW(SELW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel),
        .cmd_a(cmd_a),
        .cmd_b(cmd_b),
        .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_sel(alu_sel),
        .alu_result(alu_result),
        .alu_agrtb(alu_agrtb),
        .alu_altb(alu_altb),
        .alu_aeqb(alu_aeqb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_flags(rsp_flags),
        .acc(acc),
        .fifo_count(fifo_count)
    );

    // Stand-in ALU opcodes: pass a, add, subtract, xor, and 2a+b+4.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [SELW-1:0] sel);
        logic [WIDTH-1:0] t;
        case (sel)
            OP_PASS: t = a;
            OP_ADD:  t = a + b;
            OP_SUB:  t = a - b;
            OP_MAC:  t = (a << 1) + b + WIDTH'(4);
            default: t = a ^ b;
        endcase
        return t;
    endfunction

    function automatic logic [2:0] flag_fn(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
        return {($signed(a) > $signed(b)), ($signed(a) < $signed(b)), (a == b)};
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_a, alu_b, alu_sel);
        {alu_agrtb, alu_altb, alu_aeqb} = flag_fn(alu_a, alu_b);
    end

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [2:0]       flags;
    } rsp_t;

    rsp_t             expq[$];
    logic [WIDTH-1:0] model_acc;
    int               n_checks = 0;
    int               n_fail = 0;
    logic             last_accepted;
    int               max_count;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Commands execute strictly in acceptance order, so each result can be
    // computed the moment the command is accepted.
    task automatic modelAccept(input logic [SELW-1:0] sel, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic ua);
        logic [WIDTH-1:0] opa;
        rsp_t             r;
        opa = ua ? model_acc : a;
        r.res = alu_fn(opa, b, sel);
        r.flags = flag_fn(opa, b);
        expq.push_back(r);
        model_acc = r.res;
    endtask

    // Called one time unit after a rising edge; drives inputs, scores the
    // handshakes that the next edge will complete, then advances one cycle.
    task automatic applyStimulus(input logic v, input logic [SELW-1:0] sel,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ua, input logic rr);
        rsp_t             e;
        logic             hold;
        logic [WIDTH-1:0] hold_res;
        logic [2:0]       hold_flags;
        cmd_valid = v;
        cmd_sel = sel;
        cmd_a = a;
        cmd_b = b;
        cmd_use_acc = ua;
        rsp_ready = rr;
        last_accepted = v && cmd_ready;
        if (last_accepted) begin
            modelAccept(sel, a, b, ua);
        end
        if (rsp_valid && rr) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_rsp", 32'(rsp_result), 32'hFFFF_FFFF);
            end else begin
                e = expq.pop_front();
                checkOutput("rsp_result", 32'(rsp_result), 32'(e.res));
                checkOutput("rsp_flags", 32'(rsp_flags), 32'(e.flags));
            end
        end
        hold = rsp_valid && !rr;
        hold_res = rsp_result;
        hold_flags = rsp_flags;
        @(posedge clk);
        #1;
        if (hold) begin
            checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_result", 32'(rsp_result), 32'(hold_res));
            checkOutput("hold_flags", 32'(rsp_flags), 32'(hold_flags));
        end
        if (int'(fifo_count) > max_count) begin
            max_count = int'(fifo_count);
        end
    endtask

    task automatic idle(input logic rr);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, rr);
    endtask

    task automatic pushCmd(input logic [SELW-1:0] sel, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic ua, input logic rand_ready);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            applyStimulus(1'b1, sel, a, b, ua, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            done = last_accepted;
        end
        if (!done) begin
            checkOutput("push_timeout", 32'd0, 32'd1);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && expq.size() != 0; i++) begin
            idle(1'b1);
        end
        idle(1'b1);
        idle(1'b1);
        checkOutput("drain_pending", 32'(expq.size()), 32'd0);
        checkOutput("drain_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("drain_count", 32'(fifo_count), 32'd0);
    endtask

    // Asserts reset between edges and checks the cleared state before any
    // further clock edge and again while reset is still held.
    task automatic doReset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        expq.delete();
        model_acc = '0;
        #2;
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_acc", 32'(acc), 32'd0);
        checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
        checkOutput("rst_alu_b", 32'(alu_b), 32'd0);
        checkOutput("rst_alu_sel", 32'(alu_sel), 32'd0);
        checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_rsp_result", 32'(rsp_result), 32'd0);
        checkOutput("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_hold_count", 32'(fifo_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_acc;
        logic [SELW-1:0] ops [5];
        ops[0] = OP_PASS;
        ops[1] = OP_ADD;
        ops[2] = OP_SUB;
        ops[3] = OP_XOR;
        ops[4] = OP_MAC;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_sel = '0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_use_acc = 1'b0;
        rsp_ready = 1'b0;
        model_acc = '0;
        max_count = 0;
        @(posedge clk);
        #1;
        doReset();

        $display("[TB] single operation");
        applyStimulus(1'b1, OP_ADD, 12'd5, 12'd3, 1'b0, 1'b1);
        checkOutput("single_accept", 32'(last_accepted), 32'd1);
        checkOutput("single_count_n", 32'(fifo_count), 32'd1);
        checkOutput("single_alu_a_n", 32'(alu_a), 32'd0);
        idle(1'b1);
        checkOutput("single_alu_a", 32'(alu_a), 32'd5);
        checkOutput("single_alu_b", 32'(alu_b), 32'd3);
        checkOutput("single_alu_sel", 32'(alu_sel), 32'(OP_ADD));
        checkOutput("single_valid_n1", 32'(rsp_valid), 32'd0);
        checkOutput("single_count_n1", 32'(fifo_count), 32'd0);
        idle(1'b1);
        checkOutput("single_valid_n2", 32'(rsp_valid), 32'd1);
        checkOutput("single_result", 32'(rsp_result), 32'd8);
        checkOutput("single_flags", 32'(rsp_flags), 32'b100);
        checkOutput("single_acc", 32'(acc), 32'd8);
        drain();

        $display("[TB] accumulator chain");
        pushCmd(OP_PASS, 12'd10, 12'd0, 1'b0, 1'b0);
        pushCmd(OP_ADD, 12'hABC, 12'd7, 1'b1, 1'b0);
        pushCmd(OP_SUB, 12'h555, 12'd17, 1'b1, 1'b0);
        drain();
        checkOutput("chain_acc", 32'(acc), 32'd0);
        checkOutput("chain_flags", 32'(rsp_flags), 32'b001);

        $display("[TB] back-pressure");
        n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, OP_ADD, WIDTH'(k + 1), 12'd100, 1'b0, 1'b0);
            if (last_accepted) begin
                n_acc++;
            end
        end
        cmd_valid = 1'b0;
        checkOutput("bp_accepted", 32'(n_acc), 32'd5);
        checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("bp_fifo_count", 32'(fifo_count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            idle(1'b0);
        end
        checkOutput("bp_first_held", 32'(rsp_result), 32'(expq[0].res));
        checkOutput("bp_count_held", 32'(fifo_count), 32'd4);
        drain();

        $display("[TB] pointer wrap");
        max_count = 0;
        for (int i = 0; i < 10; i++) begin
            pushCmd(OP_MAC, WIDTH'(i), 12'd1, 1'b0, 1'b1);
        end
        drain();
        checkOutput("wrap_max_count_ok", 32'(max_count <= DEPTH), 32'd1);
        checkOutput("wrap_last_acc", 32'(acc), 32'd23);

        $display("[TB] randomized stream");
        max_count = 0;
        for (int i = 0; i < 40; i++) begin
            pushCmd(ops[$urandom_range(0, 4)], WIDTH'($urandom), WIDTH'($urandom),
                    1'($urandom_range(0, 1)), 1'b1);
        end
        drain();
        checkOutput("rand_max_count_ok", 32'(max_count <= DEPTH), 32'd1);

        $display("[TB] reset with response held");
        pushCmd(OP_ADD, 12'd40, 12'd2, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
        end
        checkOutput("held_before_rst", 32'(rsp_valid), 32'd1);
        checkOutput("acc_before_rst", 32'(acc), 32'd42);
        doReset();

        $display("[TB] reset during execute");
        applyStimulus(1'b1, OP_ADD, 12'd20, 12'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, OP_ADD, 12'd30, 12'd1, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        checkOutput("exec_alu_a", 32'(alu_a), 32'd20);
        checkOutput("exec_count", 32'(fifo_count), 32'd1);
        doReset();
        pushCmd(OP_ADD, 12'hFFF, 12'd1, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        checkOutput("post_rst_result", 32'(rsp_result), 32'd0);
        checkOutput("post_rst_flags", 32'(rsp_flags), 32'b010);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
